// File: rtl/palm_bbox_extractor_pkg.sv
// palm_bbox_extractor_pkg: shared widths, types and FSM states for the palm bounding-box extractor
package palm_bbox_extractor_pkg;
  localparam int COORD_W = 8;
  localparam int CNT_W = 16;
  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;
endpackage

// File: rtl/palm_bbox_extractor_if.sv
// palm_bbox_extractor_if: pixel stream in, palm geometry report out
interface palm_bbox_extractor_if;
  import palm_bbox_extractor_pkg::*;
  logic pix_valid;
  logic pix_sof;
  logic pix_fg;
  coord_t start_of_palm_r;
  coord_t start_of_palm_c;
  coord_t end_of_palm_r;
  coord_t end_of_palm_c;
  coord_t palm_width;
  coord_t palm_height;
  logic geom_valid;
  logic frame_err;
  modport master (
    output pix_valid, pix_sof, pix_fg,
    input start_of_palm_r, start_of_palm_c, end_of_palm_r, end_of_palm_c,
    input palm_width, palm_height, geom_valid, frame_err
  );
  modport slave (
    input pix_valid, pix_sof, pix_fg,
    output start_of_palm_r, start_of_palm_c, end_of_palm_r, end_of_palm_c,
    output palm_width, palm_height, geom_valid, frame_err
  );
endinterface

// File: rtl/palm_bbox_extractor_accum.sv
// palm_bbox_accum: min/max row/col and saturating foreground count over one frame
module palm_bbox_accum
  import palm_bbox_extractor_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   init,
  input  logic   upd,
  input  logic   fg,
  input  coord_t r,
  input  coord_t c,
  output coord_t min_r,
  output coord_t min_c,
  output coord_t max_r,
  output coord_t max_c,
  output cnt_t   count
);
  coord_t b_min_r, b_min_c, b_max_r, b_max_c;
  cnt_t b_count;
  // init restarts from the empty box so the first pixel is folded in like any other
  always_comb begin
    b_min_r = init ? '1 : min_r;
    b_min_c = init ? '1 : min_c;
    b_max_r = init ? '0 : max_r;
    b_max_c = init ? '0 : max_c;
    b_count = init ? '0 : count;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_r <= '0;
      min_c <= '0;
      max_r <= '0;
      max_c <= '0;
      count <= '0;
    end else if (init || upd) begin
      min_r <= (fg && r < b_min_r) ? r : b_min_r;
      min_c <= (fg && c < b_min_c) ? c : b_min_c;
      max_r <= (fg && r > b_max_r) ? r : b_max_r;
      max_c <= (fg && c > b_max_c) ? c : b_max_c;
      count <= (fg && b_count != '1) ? b_count + CNT_W'(1) : b_count;
    end
  end
endmodule

// File: rtl/palm_bbox_extractor.sv
// palm_bbox_extractor: raster scan FSM tracking the foreground bounding box, reported once per frame
module palm_bbox_extractor
  import palm_bbox_extractor_pkg::*;
#(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int MIN_PIXELS = 16
) (
  input logic clk,
  input logic rst,
  palm_bbox_extractor_if.slave bus
);
  state_t state, state_n;
  coord_t row, col, row_n, col_n;
  coord_t min_r, min_c, max_r, max_c;
  cnt_t count;
  logic init, accept, last, err, ok;
  always_comb begin
    init = bus.pix_valid && bus.pix_sof && state != REPORT;
    accept = bus.pix_valid && (init || state == SCAN);
    last = accept && !init && row == coord_t'(IMG_H-1) && col == coord_t'(IMG_W-1);
    err = bus.pix_valid && ((state == SCAN && bus.pix_sof) || state == REPORT);
    ok = count >= cnt_t'(MIN_PIXELS);
    row_n = init ? '0 : (accept && col == coord_t'(IMG_W-1)) ? row + 8'd1 : row;
    col_n = init ? 8'd1 : !accept ? col : (col == coord_t'(IMG_W-1)) ? '0 : col + 8'd1;
    state_n = init ? SCAN : last ? REPORT : state == REPORT ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
    end else begin
      state <= state_n;
      row <= row_n;
      col <= col_n;
    end
  end
  palm_bbox_accum u_accum (
    .clk(clk),
    .rst(rst),
    .init(init),
    .upd(accept && !init),
    .fg(bus.pix_fg),
    .r(init ? '0 : row),
    .c(init ? '0 : col),
    .min_r(min_r),
    .min_c(min_c),
    .max_r(max_r),
    .max_c(max_c),
    .count(count)
  );
  // the accumulators are final while in REPORT, so the geometry loads on the edge leaving it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.start_of_palm_r <= '0;
      bus.start_of_palm_c <= '0;
      bus.end_of_palm_r <= '0;
      bus.end_of_palm_c <= '0;
      bus.palm_width <= '0;
      bus.palm_height <= '0;
      bus.geom_valid <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.geom_valid <= state == REPORT;
      bus.frame_err <= err;
      if (state == REPORT) begin
        bus.start_of_palm_r <= ok ? min_r : '0;
        bus.start_of_palm_c <= ok ? min_c : '0;
        bus.end_of_palm_r <= ok ? max_r : '0;
        bus.end_of_palm_c <= ok ? max_c : '0;
        bus.palm_width <= ok ? max_c - min_c + 8'd1 : '0;
        bus.palm_height <= ok ? max_r - min_r + 8'd1 : '0;
      end
    end
  end
endmodule

// File: tb/tb_palm_bbox_extractor.sv
// tb_palm_bbox_extractor: small-image vector table plus full-size corner-case sequences
module tb_palm_bbox_extractor;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic v = 1'b0, s = 1'b0, f = 1'b0, sel = 1'b0;
  int tests = 0, fails = 0;
  int gvs = 0, gvb = 0, fes = 0, feb = 0;
  always #5 clk = ~clk;
  palm_bbox_extractor_if bs ();
  palm_bbox_extractor_if bb ();
  assign bs.pix_valid = v & ~sel;
  assign bs.pix_sof = s;
  assign bs.pix_fg = f;
  assign bb.pix_valid = v & sel;
  assign bb.pix_sof = s;
  assign bb.pix_fg = f;
  palm_bbox_extractor #(.IMG_W(8), .IMG_H(4), .MIN_PIXELS(16)) u_small (.clk(clk), .rst(rst), .bus(bs.slave));
  palm_bbox_extractor u_big (.clk(clk), .rst(rst), .bus(bb.slave));
  logic [7:0] o_sr, o_sc, o_er, o_ec, o_w, o_h;
  logic gv_now, fe_now;
  always_comb begin
    o_sr = sel ? bb.start_of_palm_r : bs.start_of_palm_r;
    o_sc = sel ? bb.start_of_palm_c : bs.start_of_palm_c;
    o_er = sel ? bb.end_of_palm_r : bs.end_of_palm_r;
    o_ec = sel ? bb.end_of_palm_c : bs.end_of_palm_c;
    o_w = sel ? bb.palm_width : bs.palm_width;
    o_h = sel ? bb.palm_height : bs.palm_height;
    gv_now = sel ? bb.geom_valid : bs.geom_valid;
    fe_now = sel ? bb.frame_err : bs.frame_err;
  end
  always @(posedge clk) begin
    #2;
    gvs += int'(bs.geom_valid);
    gvb += int'(bb.geom_valid);
    fes += int'(bs.frame_err);
    feb += int'(bb.frame_err);
  end
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic chk_geom(input string tag, input int sr, sc, er, ec, w, h);
    chk({tag, ".start_r"}, o_sr, sr);
    chk({tag, ".start_c"}, o_sc, sc);
    chk({tag, ".end_r"}, o_er, er);
    chk({tag, ".end_c"}, o_ec, ec);
    chk({tag, ".width"}, o_w, w);
    chk({tag, ".height"}, o_h, h);
  endtask
  task automatic px(input logic pv, input logic ps, input logic pf);
    @(negedge clk);
    v = pv;
    s = ps;
    f = pf;
  endtask
  task automatic frame(input int nr, nc, r0, r1, c0, c1, stall);
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < nc; c++) begin
        if (stall > 0 && $urandom_range(stall - 1, 0) == 0) px(0, 0, 0);
        px(1, r == 0 && c == 0, r >= r0 && r <= r1 && c >= c0 && c <= c1);
      end
  endtask
  // last pixel sampled at edge E: nothing after E, geom_valid after E+1
  task automatic finish_frame(input string tag, input logic stray);
    @(negedge clk);
    chk({tag, ".gv_early"}, gv_now, 0);
    v = stray;
    s = 1'b0;
    f = 1'b1;
    @(negedge clk);
    v = 1'b0;
    chk({tag, ".gv"}, gv_now, 1);
    chk({tag, ".frame_err"}, fe_now, stray);
  endtask
  typedef struct {
    int r0, r1, c0, c1, stall;
    int sr, sc, er, ec, w, h;
  } vec_t;
  vec_t vecs[6];
  int g0, e0;
  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    vecs[0] = '{1, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{0, 2, 0, 4, 0, 0, 0, 0, 0, 0, 0};
    vecs[2] = '{0, 3, 0, 3, 0, 0, 0, 3, 3, 4, 4};
    vecs[3] = '{0, 3, 0, 7, 3, 0, 0, 3, 7, 8, 4};
    vecs[4] = '{1, 3, 2, 7, 2, 1, 2, 3, 7, 6, 3};
    vecs[5] = '{2, 3, 0, 7, 0, 2, 0, 3, 7, 8, 2};
    #1 rst = 1'b1;
    #3;
    sel = 1'b1;
    chk_geom("reset_big", 0, 0, 0, 0, 0, 0);
    chk("reset_big.gv", gv_now, 0);
    chk("reset_big.fe", fe_now, 0);
    sel = 1'b0;
    chk("reset_small.width", o_w, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      g0 = gvs;
      frame(4, 8, vecs[i].r0, vecs[i].r1, vecs[i].c0, vecs[i].c1, vecs[i].stall);
      finish_frame($sformatf("vec%0d", i), 1'b0);
      chk_geom($sformatf("vec%0d", i), vecs[i].sr, vecs[i].sc, vecs[i].er, vecs[i].ec, vecs[i].w, vecs[i].h);
      @(negedge clk);
      chk($sformatf("vec%0d.gv_pulses", i), gvs - g0, 1);
    end
    chk("small.frame_err_count", fes, 0);
    sel = 1'b1;
    px(1, 0, 1);
    px(1, 0, 1);
    px(0, 0, 0);
    @(negedge clk);
    chk("idle_stray.frame_err", feb, 0);
    g0 = gvb;
    frame(120, 160, 30, 89, 40, 119, 0);
    finish_frame("rect", 1'b1);
    chk_geom("rect", 30, 40, 89, 119, 80, 60);
    @(negedge clk);
    chk("rect.gv_pulses", gvb - g0, 1);
    chk("rect.frame_err_count", feb, 1);
    g0 = gvb;
    frame(120, 160, 0, 119, 0, 159, 32);
    finish_frame("full_stall", 1'b0);
    chk_geom("full_stall", 0, 0, 119, 159, 160, 120);
    g0 = gvb;
    e0 = feb;
    frame(50, 160, 0, 119, 0, 159, 0);
    frame(120, 160, 10, 19, 5, 9, 0);
    finish_frame("early_sof", 1'b0);
    chk_geom("early_sof", 10, 5, 19, 9, 5, 10);
    @(negedge clk);
    chk("early_sof.gv_pulses", gvb - g0, 1);
    chk("early_sof.frame_err_pulses", feb - e0, 1);
    g0 = gvb;
    frame(5, 160, 0, 119, 0, 159, 0);
    @(negedge clk);
    v = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_geom("async_rst", 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    frame(120, 160, 0, 0, 0, 14, 0);
    finish_frame("after_rst_15px", 1'b0);
    chk_geom("after_rst_15px", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("after_rst.gv_pulses", gvb - g0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
